// File: rtl/id_ex_pipe_reg.sv
// ============================================================================
// id_ex_pipe_reg
//   Pipeline register between the Decode (D) and Execute (E) stages of an
//   in-order RISC-V core. Every D-stage field is captured into a matching
//   registered E-stage output. There is no combinational path from any input
//   to any output.
//
//   Edge behaviour, in priority order:
//     reset=0                 -> clear every E output (and the bubble counter)
//     FlushE=1                -> load a bubble (all E outputs zero)
//     StallE=1                -> hold every E output
//     ValidD=0                -> load a bubble (an empty decode slot must not
//                                carry write enables into EX)
//     otherwise               -> capture all D inputs
//
//   Optional feature macro: ID_EX_BUBBLE_CNT_EN
//     When defined, adds output BubbleCntE [31:0], a free-running count of
//     edges that loaded a bubble (wraps 0xFFFFFFFF -> 0). Stall-hold edges do
//     not count. Without the macro the port does not exist.
//
// Ports
//   clk, reset (sync, active-low), StallE, FlushE
//   Control in : RegWriteD, ResultSrcD[1:0], MemWriteD, JumpD, jalrD, BranchD,
//                ALUSrcD, ALUControlD[3:0], funct3D[2:0], PredTakenD, ValidD
//   Data in    : RD1D, RD2D, PCD, ImmExtD, PCPlus4D, PredTargetD [XLEN-1:0],
//                Rs1D, Rs2D, RdD [4:0]
//   Outputs    : same names with suffix E, same widths (+ BubbleCntE)
// ============================================================================
module id_ex_pipe_reg #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            StallE,
    input  logic            FlushE,
    input  logic            RegWriteD,
    input  logic [1:0]      ResultSrcD,
    input  logic            MemWriteD,
    input  logic            JumpD,
    input  logic            jalrD,
    input  logic            BranchD,
    input  logic            ALUSrcD,
    input  logic [3:0]      ALUControlD,
    input  logic [2:0]      funct3D,
    input  logic            PredTakenD,
    input  logic            ValidD,
    input  logic [XLEN-1:0] RD1D,
    input  logic [XLEN-1:0] RD2D,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] ImmExtD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic [XLEN-1:0] PredTargetD,
    input  logic [4:0]      Rs1D,
    input  logic [4:0]      Rs2D,
    input  logic [4:0]      RdD,
    output logic            RegWriteE,
    output logic [1:0]      ResultSrcE,
    output logic            MemWriteE,
    output logic            JumpE,
    output logic            jalrE,
    output logic            BranchE,
    output logic            ALUSrcE,
    output logic [3:0]      ALUControlE,
    output logic [2:0]      funct3E,
    output logic            PredTakenE,
    output logic            ValidE,
    output logic [XLEN-1:0] RD1E,
    output logic [XLEN-1:0] RD2E,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] ImmExtE,
    output logic [XLEN-1:0] PCPlus4E,
    output logic [XLEN-1:0] PredTargetE,
    output logic [4:0]      Rs1E,
    output logic [4:0]      Rs2E,
    output logic [4:0]      RdE
`ifdef ID_EX_BUBBLE_CNT_EN
    ,
    output logic [31:0]     BubbleCntE
`endif
);

    // One packed record for the whole stage so a bubble is simply all-zero.
    typedef struct packed {
        logic            reg_write;
        logic [1:0]      result_src;
        logic            mem_write;
        logic            jump;
        logic            jalr;
        logic            branch;
        logic            alu_src;
        logic [3:0]      alu_control;
        logic [2:0]      funct3;
        logic            pred_taken;
        logic            valid;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm_ext;
        logic [XLEN-1:0] pc_plus4;
        logic [XLEN-1:0] pred_target;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
    } stage_t;

    stage_t w_d;
    stage_t w_next;
    stage_t r_stage;
    logic   w_bubble;
    logic   w_hold;

    assign w_d = '{
        reg_write:   RegWriteD,
        result_src:  ResultSrcD,
        mem_write:   MemWriteD,
        jump:        JumpD,
        jalr:        jalrD,
        branch:      BranchD,
        alu_src:     ALUSrcD,
        alu_control: ALUControlD,
        funct3:      funct3D,
        pred_taken:  PredTakenD,
        valid:       ValidD,
        rd1:         RD1D,
        rd2:         RD2D,
        pc:          PCD,
        imm_ext:     ImmExtD,
        pc_plus4:    PCPlus4D,
        pred_target: PredTargetD,
        rs1:         Rs1D,
        rs2:         Rs2D,
        rd:          RdD
    };

    // Flush beats stall; an invalid slot only becomes a bubble when the stage
    // actually advances (a stalled stage keeps its current contents).
    always_comb begin
        w_bubble = FlushE | (~StallE & ~ValidD);
        w_hold   = StallE & ~FlushE;
        w_next   = w_d;
        if (w_bubble) begin
            w_next = '0;
        end else begin
            w_next = w_d;
        end
    end

    // Stage register: reset overrides stall and flush.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_stage <= '0;
        end else if (w_hold) begin
            r_stage <= r_stage;
        end else begin
            r_stage <= w_next;
        end
    end

    assign RegWriteE   = r_stage.reg_write;
    assign ResultSrcE  = r_stage.result_src;
    assign MemWriteE   = r_stage.mem_write;
    assign JumpE       = r_stage.jump;
    assign jalrE       = r_stage.jalr;
    assign BranchE     = r_stage.branch;
    assign ALUSrcE     = r_stage.alu_src;
    assign ALUControlE = r_stage.alu_control;
    assign funct3E     = r_stage.funct3;
    assign PredTakenE  = r_stage.pred_taken;
    assign ValidE      = r_stage.valid;
    assign RD1E        = r_stage.rd1;
    assign RD2E        = r_stage.rd2;
    assign PCE         = r_stage.pc;
    assign ImmExtE     = r_stage.imm_ext;
    assign PCPlus4E    = r_stage.pc_plus4;
    assign PredTargetE = r_stage.pred_target;
    assign Rs1E        = r_stage.rs1;
    assign Rs2E        = r_stage.rs2;
    assign RdE         = r_stage.rd;

`ifdef ID_EX_BUBBLE_CNT_EN
    logic [31:0] r_bubble_cnt;

    // Count edges that load a bubble; natural 32-bit wrap.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_bubble_cnt <= 32'd0;
        end else if (w_bubble) begin
            r_bubble_cnt <= r_bubble_cnt + 32'd1;
        end else begin
            r_bubble_cnt <= r_bubble_cnt;
        end
    end

    assign BubbleCntE = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
module tb_id_ex_pipe_reg;

    typedef struct packed {
        logic        regwrite;
        logic [1:0]  resultsrc;
        logic        memwrite;
        logic        jump;
        logic        jalr;
        logic        branch;
        logic        alusrc;
        logic [3:0]  aluctl;
        logic [2:0]  funct3;
        logic        predtaken;
        logic        valid;
        logic [31:0] rd1v;
        logic [31:0] rd2v;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] pcplus4;
        logic [31:0] predtarget;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } bundle_t;

    typedef struct {
        logic        rst_n;
        logic        stall;
        logic        flush;
        logic        ones;
        logic        valid;
        logic        regwrite;
        logic        memwrite;
        logic        branch;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        e_rw;
        logic        e_mw;
        logic        e_br;
        logic        e_v;
        logic [4:0]  e_rd;
        logic [31:0] e_imm;
        logic [31:0] e_cnt;
    } vec_t;

    logic    clk = 1'b0;
    logic    reset, stall, flush;
    bundle_t d, e, model;
    logic [31:0] cnt_model;
    int      n_cmp = 0;
    int      n_fail = 0;
`ifdef ID_EX_BUBBLE_CNT_EN
    logic [31:0] cnt_e;
`endif

    always #5 clk = ~clk;

    id_ex_pipe_reg #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .StallE(stall), .FlushE(flush),
        .RegWriteD(d.regwrite), .ResultSrcD(d.resultsrc), .MemWriteD(d.memwrite),
        .JumpD(d.jump), .jalrD(d.jalr), .BranchD(d.branch), .ALUSrcD(d.alusrc),
        .ALUControlD(d.aluctl), .funct3D(d.funct3), .PredTakenD(d.predtaken),
        .ValidD(d.valid), .RD1D(d.rd1v), .RD2D(d.rd2v), .PCD(d.pc),
        .ImmExtD(d.imm), .PCPlus4D(d.pcplus4), .PredTargetD(d.predtarget),
        .Rs1D(d.rs1), .Rs2D(d.rs2), .RdD(d.rd),
        .RegWriteE(e.regwrite), .ResultSrcE(e.resultsrc), .MemWriteE(e.memwrite),
        .JumpE(e.jump), .jalrE(e.jalr), .BranchE(e.branch), .ALUSrcE(e.alusrc),
        .ALUControlE(e.aluctl), .funct3E(e.funct3), .PredTakenE(e.predtaken),
        .ValidE(e.valid), .RD1E(e.rd1v), .RD2E(e.rd2v), .PCE(e.pc),
        .ImmExtE(e.imm), .PCPlus4E(e.pcplus4), .PredTargetE(e.predtarget),
        .Rs1E(e.rs1), .Rs2E(e.rs2), .RdE(e.rd)
`ifdef ID_EX_BUBBLE_CNT_EN
        , .BubbleCntE(cnt_e)
`endif
    );

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference model: what the E stage should contain after one edge,
    // stated directly from the behavioural rules.
    task automatic model_edge();
        logic bubble;
        if (!reset) begin
            model = '0;
            cnt_model = 32'd0;
        end else begin
            bubble = flush || (!stall && !d.valid);
            if (bubble) begin
                model = '0;
                cnt_model = cnt_model + 32'd1;
            end else if (!stall) begin
                model = d;
            end
        end
    endtask

    // Apply current inputs for one clock edge and check the whole stage.
    task automatic step(input string name);
        model_edge();
        @(posedge clk);
        #1;
        chk({name, "_all"}, 256'(e), 256'(model));
`ifdef ID_EX_BUBBLE_CNT_EN
        chk({name, "_cnt"}, 256'(cnt_e), 256'(cnt_model));
`endif
    endtask

    vec_t vec[12];

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0; d = '0;
        model = '0; cnt_model = 32'd0;
        //        rst  stl  fl   ones v    rw   mw   br   rd     imm        | e_rw e_mw e_br e_v e_rd  e_imm      e_cnt
        vec[0]  = '{1'b0,1'b0,1'b0,1'b1,1'b1,1'b1,1'b1,1'b1,5'd31,32'hFFFFFFFF,1'b0,1'b0,1'b0,1'b0,5'd0, 32'h0,  32'd0};
        vec[1]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,5'd5, 32'h10,     1'b1,1'b0,1'b0,1'b1,5'd5, 32'h10, 32'd0};
        vec[2]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,5'd0, 32'h20,     1'b0,1'b1,1'b0,1'b1,5'd0, 32'h20, 32'd0};
        vec[3]  = '{1'b1,1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,5'd9, 32'h99,     1'b0,1'b1,1'b0,1'b1,5'd0, 32'h20, 32'd0};
        vec[4]  = '{1'b1,1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,5'd10,32'h9A,     1'b0,1'b1,1'b0,1'b1,5'd0, 32'h20, 32'd0};
        vec[5]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,5'd11,32'h9B,     1'b0,1'b1,1'b0,1'b1,5'd0, 32'h20, 32'd0};
        vec[6]  = '{1'b1,1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,1'b1,5'd0, 32'h40,     1'b0,1'b0,1'b0,1'b0,5'd0, 32'h0,  32'd1};
        vec[7]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,5'd7, 32'h7,      1'b0,1'b0,1'b0,1'b0,5'd0, 32'h0,  32'd2};
        vec[8]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,5'd3, 32'h8,      1'b1,1'b0,1'b0,1'b1,5'd3, 32'h8,  32'd2};
        vec[9]  = '{1'b0,1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,5'd4, 32'hC,      1'b0,1'b0,1'b0,1'b0,5'd0, 32'h0,  32'd0};
        vec[10] = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,5'd12,32'h30,     1'b1,1'b0,1'b0,1'b1,5'd12,32'h30, 32'd0};
        vec[11] = '{1'b1,1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,5'd13,32'h34,     1'b0,1'b0,1'b0,1'b0,5'd0, 32'h0,  32'd1};

        repeat (2) @(negedge clk);

        // Directed table: reset, lw, sw, 3-cycle stall, flush+stall, invalid slot, reset mid-stall.
        for (int i = 0; i < 12; i++) begin
            reset = vec[i].rst_n;
            stall = vec[i].stall;
            flush = vec[i].flush;
            if (vec[i].ones) begin
                d = '1;
            end else begin
                d = '0;
                d.valid      = vec[i].valid;
                d.regwrite   = vec[i].regwrite;
                d.memwrite   = vec[i].memwrite;
                d.branch     = vec[i].branch;
                d.rd         = vec[i].rd;
                d.imm        = vec[i].imm;
                d.resultsrc  = vec[i].regwrite ? 2'b01 : 2'b00;
                d.alusrc     = ~vec[i].branch;
                d.pc         = 32'h1000 + 32'(i) * 32'd4;
                d.pcplus4    = d.pc + 32'd4;
                d.predtaken  = vec[i].branch;
                d.predtarget = 32'h2000 + 32'(i);
                d.rs1        = 5'(i + 1);
                d.rs2        = 5'(i + 2);
            end
            step($sformatf("row%0d", i));
            chk($sformatf("row%0d_key", i),
                256'({e.regwrite, e.memwrite, e.branch, e.valid, e.rd, e.imm}),
                256'({vec[i].e_rw, vec[i].e_mw, vec[i].e_br, vec[i].e_v, vec[i].e_rd, vec[i].e_imm}));
`ifdef ID_EX_BUBBLE_CNT_EN
            chk($sformatf("row%0d_cntkey", i), 256'(cnt_e), 256'(vec[i].e_cnt));
`endif
            @(negedge clk);
        end

`ifdef ID_EX_BUBBLE_CNT_EN
        // Counter wrap: preset to all-ones, then one flush.
        force dut.r_bubble_cnt = 32'hFFFFFFFF;
        #1;
        release dut.r_bubble_cnt;
        cnt_model = 32'hFFFFFFFF;
        reset = 1'b1; stall = 1'b0; flush = 1'b1;
        step("wrap");
        chk("wrap_zero", 256'(cnt_e), 256'(32'h0));
        @(negedge clk);
`endif

        // Randomized traffic against the reference model.
        for (int c = 0; c < 400; c++) begin
            reset = ($urandom_range(0, 15) != 0);
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 7) == 0);
            d.regwrite   = 1'($urandom);
            d.resultsrc  = 2'($urandom);
            d.memwrite   = 1'($urandom);
            d.jump       = 1'($urandom);
            d.jalr       = 1'($urandom);
            d.branch     = 1'($urandom);
            d.alusrc     = 1'($urandom);
            d.aluctl     = 4'($urandom);
            d.funct3     = 3'($urandom);
            d.predtaken  = 1'($urandom);
            d.valid      = ($urandom_range(0, 3) != 0);
            d.rd1v       = $urandom;
            d.rd2v       = $urandom;
            d.pc         = $urandom;
            d.imm        = $urandom;
            d.pcplus4    = $urandom;
            d.predtarget = $urandom;
            d.rs1        = 5'($urandom);
            d.rs2        = 5'($urandom);
            d.rd         = 5'($urandom);
            step($sformatf("rand%0d", c));
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
